// File: rtl/tetris_input_pkg.sv
// Shared encodings for the button-to-command front end: command codes and
// the auto-repeat channel state encoding.
package tetris_input_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_ROTATE = 3'd4;
    localparam logic [2:0] CMD_DROP   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } chan_state_t;

endpackage

// File: rtl/repeat_channel.sv
// Auto-repeat channel: one event on press, a second after DAS_DELAY+1 cycles,
// then one every ARR_PERIOD+1 cycles while the button stays held.
//   state     | meaning
//   ST_IDLE   | waiting for a fresh press (rising edge)
//   ST_DELAY  | pressed, counting the initial auto-shift delay
//   ST_REPEAT | held past the delay, counting the repeat period
import tetris_input_pkg::*;

module repeat_channel #(
    parameter int DAS_DELAY  = 17_000_000,
    parameter int ARR_PERIOD = 4_999_999,
    parameter int CNT_W      = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_inhibit,
    output logic o_event
);

    localparam logic [CNT_W-1:0] DAS_C = CNT_W'(DAS_DELAY);
    localparam logic [CNT_W-1:0] ARR_C = CNT_W'(ARR_PERIOD);

    chan_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_btn_prev;
    logic             w_rise;
    logic             w_hold;

    assign w_rise = i_btn & ~r_btn_prev;
    assign w_hold = i_btn & ~i_inhibit;

    // Previous level resets high so a button held through reset needs a re-press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_btn_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_btn_prev <= i_btn;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_hold) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == DAS_C) begin
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (r_cnt == ARR_C) w_cnt_nxt = '0;
                    else                w_cnt_nxt = r_cnt + 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Release or opposition suppresses any same-cycle expiry.
    always_comb begin
        o_event = 1'b0;
        if (w_hold) begin
            case (r_state)
                ST_IDLE:   o_event = w_rise;
                ST_DELAY:  o_event = (r_cnt == DAS_C);
                ST_REPEAT: o_event = (r_cnt == ARR_C);
                default:   o_event = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/button_cmd_repeater.sv
// Turns debounced button levels into single-cycle game commands with
// auto-repeat on LEFT/RIGHT/DOWN, priority arbitration and a one-entry output slot.
import tetris_input_pkg::*;

module button_cmd_repeater #(
    parameter int DAS_DELAY  = 17_000_000,
    parameter int ARR_PERIOD = 4_999_999,
    parameter int CNT_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_rotate,
    input  logic       btn_drop,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       cmd_dropped
);

    logic       r_rotate_prev, r_drop_prev;
    logic       r_cmd_valid, r_cmd_dropped;
    logic [2:0] r_cmd;
    logic       w_inhibit_lr;
    logic       w_ev_left, w_ev_right, w_ev_down, w_ev_rotate, w_ev_drop;
    logic [4:0] w_ev_vec;
    logic       w_any, w_multi, w_load;
    logic [2:0] w_sel;

    assign w_inhibit_lr = btn_left & btn_right;

    repeat_channel #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_left (
        .clk(clk), .reset(reset), .i_btn(btn_left), .i_inhibit(w_inhibit_lr), .o_event(w_ev_left));
    repeat_channel #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_right (
        .clk(clk), .reset(reset), .i_btn(btn_right), .i_inhibit(w_inhibit_lr), .o_event(w_ev_right));
    repeat_channel #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_down (
        .clk(clk), .reset(reset), .i_btn(btn_down), .i_inhibit(1'b0), .o_event(w_ev_down));

    assign w_ev_rotate = btn_rotate & ~r_rotate_prev;
    assign w_ev_drop   = btn_drop & ~r_drop_prev;

    assign w_ev_vec = {w_ev_drop, w_ev_rotate, w_ev_down, w_ev_left, w_ev_right};
    assign w_any    = |w_ev_vec;
    assign w_multi  = ($countones(w_ev_vec) > 1);
    assign w_load   = w_any & (~r_cmd_valid | cmd_ready);

    always_comb begin
        w_sel = CMD_NONE;
        if      (w_ev_drop)   w_sel = CMD_DROP;
        else if (w_ev_rotate) w_sel = CMD_ROTATE;
        else if (w_ev_down)   w_sel = CMD_DOWN;
        else if (w_ev_left)   w_sel = CMD_LEFT;
        else if (w_ev_right)  w_sel = CMD_RIGHT;
    end

    // Events are never queued: anything not loaded this cycle is reported and lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rotate_prev <= 1'b1;
            r_drop_prev   <= 1'b1;
            r_cmd_valid   <= 1'b0;
            r_cmd         <= CMD_NONE;
            r_cmd_dropped <= 1'b0;
        end else begin
            r_rotate_prev <= btn_rotate;
            r_drop_prev   <= btn_drop;
            r_cmd_dropped <= 1'b0;
            if (w_load) begin
                r_cmd_valid   <= 1'b1;
                r_cmd         <= w_sel;
                r_cmd_dropped <= w_multi;
            end else if (w_any) begin
                r_cmd_dropped <= 1'b1;
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
                r_cmd       <= CMD_NONE;
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd         = r_cmd;
    assign cmd_dropped = r_cmd_dropped;

endmodule

// File: tb/tb_button_cmd_repeater.sv
// Randomized and directed stimulus for button_cmd_repeater, checked every cycle
// against a time-based behavioural model of press/repeat timing and the output slot.
module tb_button_cmd_repeater;

    localparam int DAS = 9;
    localparam int ARR = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_down, btn_rotate, btn_drop;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_dropped;

    always #5 clk = ~clk;

    button_cmd_repeater #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR), .CNT_W(25)) dut (
        .clk(clk), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .btn_rotate(btn_rotate), .btn_drop(btn_drop),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_dropped(cmd_dropped));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state: button index 0 left, 1 right, 2 down, 3 rotate, 4 drop
    int m_valid, m_cmd, m_drop;
    bit m_prev[5];
    bit m_active[3];
    int m_age[3];
    int seen[8];
    int seen_drop;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_cmd = 0; m_drop = 0;
        for (int i = 0; i < 5; i++) m_prev[i] = 1'b1;
        for (int i = 0; i < 3; i++) begin m_active[i] = 1'b0; m_age[i] = 0; end
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 8; i++) seen[i] = 0;
        seen_drop = 0;
    endtask

    task automatic model_step(input bit [4:0] b, input bit rdy);
        bit ev[5];
        int n;
        int pick;
        for (int ch = 0; ch < 3; ch++) begin
            bit inh;
            inh = (ch < 2) && b[0] && b[1];
            ev[ch] = 1'b0;
            if (!b[ch] || inh) begin
                m_active[ch] = 1'b0;
            end else if (!m_prev[ch]) begin
                m_active[ch] = 1'b1;
                m_age[ch]    = 0;
                ev[ch]       = 1'b1;
            end else if (m_active[ch]) begin
                m_age[ch]++;
                ev[ch] = (m_age[ch] > DAS) && ((m_age[ch] - (DAS + 1)) % (ARR + 1) == 0);
            end
        end
        ev[3] = b[3] && !m_prev[3];
        ev[4] = b[4] && !m_prev[4];
        n = 0;
        for (int i = 0; i < 5; i++) n += int'(ev[i]);
        if      (ev[4]) pick = 5;
        else if (ev[3]) pick = 4;
        else if (ev[2]) pick = 3;
        else if (ev[0]) pick = 1;
        else            pick = 2;
        m_drop = 0;
        if (n > 0) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_cmd = pick; m_drop = (n > 1) ? 1 : 0;
            end else begin
                m_drop = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0; m_cmd = 0;
        end
        for (int i = 0; i < 5; i++) m_prev[i] = b[i];
    endtask

    // One clock: check outputs of the previous edge, then drive and advance the model.
    task automatic step(input bit [4:0] b, input bit rdy, input bit rst);
        @(negedge clk);
        chk("cmd_valid", int'(cmd_valid), m_valid);
        chk("cmd", int'(cmd), m_cmd);
        chk("cmd_dropped", int'(cmd_dropped), m_drop);
        if (cmd_valid) seen[cmd]++;
        if (cmd_dropped) seen_drop++;
        btn_left   = b[0];
        btn_right  = b[1];
        btn_down   = b[2];
        btn_rotate = b[3];
        btn_drop   = b[4];
        cmd_ready  = rdy;
        reset      = rst;
        if (rst) model_reset();
        else     model_step(b, rdy);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'b00000, 1'b1, 1'b0);
    endtask

    initial begin
        bit [4:0] rb;
        bit       rr, rs;
        reset = 1'b1; cmd_ready = 1'b1;
        btn_left = 0; btn_right = 0; btn_down = 0; btn_rotate = 0; btn_drop = 0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        chk("reset_valid", int'(cmd_valid), 0);
        chk("reset_cmd", int'(cmd), 0);
        chk("reset_dropped", int'(cmd_dropped), 0);
        idle(3);

        // rotate held long: one command only
        clear_seen();
        for (int i = 0; i < 100; i++) step(5'b01000, 1'b1, 1'b0);
        idle(5);
        chk("t1_rotate_count", seen[4], 1);
        chk("t1_other_count", seen[1] + seen[2] + seen[3] + seen[5], 0);

        // left held 30 cycles: press plus five repeats
        clear_seen();
        for (int i = 0; i < 30; i++) step(5'b00001, 1'b1, 1'b0);
        idle(20);
        chk("t2_left_count", seen[1], 6);

        // left+right opposed, down pulsed, then right released
        clear_seen();
        for (int i = 0; i < 40; i++) step((i == 20) ? 5'b00111 : 5'b00011, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(5'b00001, 1'b1, 1'b0);
        idle(5);
        chk("t3_down_count", seen[3], 1);
        chk("t3_lr_count", seen[1] + seen[2], 0);

        // slot full, not ready: later drop is discarded
        clear_seen();
        step(5'b00000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(5'b01000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(5'b11000, 1'b0, 1'b0);
        idle(5);
        chk("t4_dropped_pulses", seen_drop, 1);
        chk("t4_drop_cmd_count", seen[5], 0);

        // drop and rotate together
        clear_seen();
        for (int i = 0; i < 5; i++) step(5'b11000, 1'b1, 1'b0);
        idle(5);
        chk("t5_drop_count", seen[5], 1);
        chk("t5_rotate_count", seen[4], 0);
        chk("t5_dropped_pulses", seen_drop, 1);

        // reset while left repeats; held left stays silent until re-pressed
        for (int i = 0; i < 20; i++) step(5'b00001, 1'b1, 1'b0);
        step(5'b00001, 1'b1, 1'b1);
        step(5'b00001, 1'b1, 1'b1);
        clear_seen();
        for (int i = 0; i < 20; i++) step(5'b00001, 1'b1, 1'b0);
        chk("t6_no_left_after_reset", seen[1], 0);
        step(5'b00000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(5'b00001, 1'b1, 1'b0);
        idle(3);
        chk("t6_left_after_repress", seen[1], 1);

        // randomized long-hold traffic with backpressure and rare resets
        rb = 5'b00000;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 15) == 0) rb[k] = ~rb[k];
            rr = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 599) == 0);
            step(rb, rr, rs);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
